// File: rtl/float_unpack_stage.sv
// ---------------------------------------------------------------------------
// float_unpack_stage
//
// Two-stage pipelined unpacker for packed IEEE-754 words. S1 captures the raw
// word; the S1->S2 transfer splits it into sign/exponent/significand and
// classifies it. All io_out_* ports come straight from S2 registers.
//
// Ports:
//   clock               single clock, rising edge
//   reset               asynchronous, active-low reset
//   io_in_valid/ready   input stream handshake
//   io_in_bits          packed word {sign, exponent[EXP_W], significand[SIG_W]}
//   io_flush            synchronous drop of both pipeline stages
//   io_out_valid/ready  output stream handshake
//   io_out_sign         sign field
//   io_out_exponent     exponent field
//   io_out_significand  significand field
//   io_out_class        0=zero 1=subnormal 2=normal 3=inf 4=qNaN 5=sNaN
//
// Optional build macro FLOAT_UNPACK_STATS_EN adds:
//   io_stats_clear      synchronous clear of both counters (wins over increment)
//   io_nan_count        saturating count of delivered NaN bundles
//   io_subnormal_count  saturating count of delivered subnormal bundles
// ---------------------------------------------------------------------------
module float_unpack_stage #(
  parameter int EXP_W = 8,
  parameter int SIG_W = 23
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  input  logic [EXP_W+SIG_W:0]   io_in_bits,
  input  logic                   io_flush,
`ifdef FLOAT_UNPACK_STATS_EN
  input  logic                   io_stats_clear,
  output logic [15:0]            io_nan_count,
  output logic [15:0]            io_subnormal_count,
`endif
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic                   io_out_sign,
  output logic [EXP_W-1:0]       io_out_exponent,
  output logic [SIG_W-1:0]       io_out_significand,
  output logic [2:0]             io_out_class
);

  localparam int IN_W = 1 + EXP_W + SIG_W;

  localparam logic [2:0] CLS_ZERO   = 3'd0;
  localparam logic [2:0] CLS_SUBNRM = 3'd1;
  localparam logic [2:0] CLS_NORMAL = 3'd2;
  localparam logic [2:0] CLS_INF    = 3'd3;
  localparam logic [2:0] CLS_QNAN   = 3'd4;
  localparam logic [2:0] CLS_SNAN   = 3'd5;

  // Field classification; the significand MSB is the quiet bit for NaNs.
  function automatic logic [2:0] classify(input logic [EXP_W-1:0] e,
                                          input logic [SIG_W-1:0] s);
    logic [2:0] c;
    c = CLS_NORMAL;
    if (e == {EXP_W{1'b0}}) begin
      if (s == {SIG_W{1'b0}}) begin
        c = CLS_ZERO;
      end else begin
        c = CLS_SUBNRM;
      end
    end else if (e == {EXP_W{1'b1}}) begin
      if (s == {SIG_W{1'b0}}) begin
        c = CLS_INF;
      end else if (s[SIG_W-1]) begin
        c = CLS_QNAN;
      end else begin
        c = CLS_SNAN;
      end
    end else begin
      c = CLS_NORMAL;
    end
    return c;
  endfunction

  logic            s1_valid_r;
  logic [IN_W-1:0] s1_word_r;
  logic            s2_valid_r;
  logic            s2_sign_r;
  logic [EXP_W-1:0] s2_exp_r;
  logic [SIG_W-1:0] s2_sig_r;
  logic [2:0]      s2_class_r;

  logic            s2_free_s;
  logic            s1_free_s;
  logic            in_fire_s;
  logic            s1_adv_s;
  logic            out_fire_s;
  logic [EXP_W-1:0] s1_exp_s;
  logic [SIG_W-1:0] s1_sig_s;
  logic [2:0]      s1_class_s;

  // Handshake and decode terms; io_in_ready intentionally sees io_out_ready.
  always_comb begin
    s2_free_s  = !s2_valid_r || io_out_ready;
    s1_free_s  = !s1_valid_r || s2_free_s;
    in_fire_s  = io_in_valid && s1_free_s;
    s1_adv_s   = s1_valid_r && s2_free_s;
    out_fire_s = s2_valid_r && io_out_ready;
    s1_exp_s   = s1_word_r[IN_W-2 -: EXP_W];
    s1_sig_s   = s1_word_r[SIG_W-1:0];
    s1_class_s = classify(s1_exp_s, s1_sig_s);
  end

  assign io_in_ready = s1_free_s;

  // S1 stage: raw word capture. Flush drops valid and leaves data untouched.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_r <= 1'b0;
      s1_word_r  <= {IN_W{1'b0}};
    end else if (io_flush) begin
      s1_valid_r <= 1'b0;
    end else if (in_fire_s) begin
      s1_valid_r <= 1'b1;
      s1_word_r  <= io_in_bits;
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // S2 stage: decoded fields and class, which are the output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_valid_r <= 1'b0;
      s2_sign_r  <= 1'b0;
      s2_exp_r   <= {EXP_W{1'b0}};
      s2_sig_r   <= {SIG_W{1'b0}};
      s2_class_r <= CLS_ZERO;
    end else if (io_flush) begin
      s2_valid_r <= 1'b0;
    end else if (s1_adv_s) begin
      s2_valid_r <= 1'b1;
      s2_sign_r  <= s1_word_r[IN_W-1];
      s2_exp_r   <= s1_exp_s;
      s2_sig_r   <= s1_sig_s;
      s2_class_r <= s1_class_s;
    end else if (out_fire_s) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  assign io_out_valid       = s2_valid_r;
  assign io_out_sign        = s2_sign_r;
  assign io_out_exponent    = s2_exp_r;
  assign io_out_significand = s2_sig_r;
  assign io_out_class       = s2_class_r;

`ifdef FLOAT_UNPACK_STATS_EN
  logic [15:0] nan_cnt_r;
  logic [15:0] sub_cnt_r;
  logic        nan_inc_s;
  logic        sub_inc_s;

  // A handshake coincident with a flush still counts as delivered.
  always_comb begin
    nan_inc_s = out_fire_s && ((s2_class_r == CLS_QNAN) || (s2_class_r == CLS_SNAN));
    sub_inc_s = out_fire_s && (s2_class_r == CLS_SUBNRM);
  end

  // Saturating NaN counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nan_cnt_r <= 16'd0;
    end else if (io_stats_clear) begin
      nan_cnt_r <= 16'd0;
    end else if (nan_inc_s && (nan_cnt_r != 16'hFFFF)) begin
      nan_cnt_r <= nan_cnt_r + 16'd1;
    end else begin
      nan_cnt_r <= nan_cnt_r;
    end
  end

  // Saturating subnormal counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sub_cnt_r <= 16'd0;
    end else if (io_stats_clear) begin
      sub_cnt_r <= 16'd0;
    end else if (sub_inc_s && (sub_cnt_r != 16'hFFFF)) begin
      sub_cnt_r <= sub_cnt_r + 16'd1;
    end else begin
      sub_cnt_r <= sub_cnt_r;
    end
  end

  assign io_nan_count       = nan_cnt_r;
  assign io_subnormal_count = sub_cnt_r;
`endif

endmodule

// File: tb/tb_float_unpack_stage.sv
// ---------------------------------------------------------------------------
// Bench for float_unpack_stage: directed vector table, hand-written stall,
// flush and reset sequences, and a randomized run checked against a queue
// model of the pipeline contents.
// ---------------------------------------------------------------------------
module tb_float_unpack_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [31:0] io_in_bits;
  logic        io_flush;
  logic        io_out_valid;
  logic        io_out_ready;
  logic        io_out_sign;
  logic [7:0]  io_out_exponent;
  logic [22:0] io_out_significand;
  logic [2:0]  io_out_class;
`ifdef FLOAT_UNPACK_STATS_EN
  logic        io_stats_clear;
  logic [15:0] io_nan_count;
  logic [15:0] io_subnormal_count;
`endif

  always #5 clock = ~clock;

  float_unpack_stage #(.EXP_W(8), .SIG_W(23)) dut (
    .clock              (clock),
    .reset              (reset),
    .io_in_valid        (io_in_valid),
    .io_in_ready        (io_in_ready),
    .io_in_bits         (io_in_bits),
    .io_flush           (io_flush),
`ifdef FLOAT_UNPACK_STATS_EN
    .io_stats_clear     (io_stats_clear),
    .io_nan_count       (io_nan_count),
    .io_subnormal_count (io_subnormal_count),
`endif
    .io_out_valid       (io_out_valid),
    .io_out_ready       (io_out_ready),
    .io_out_sign        (io_out_sign),
    .io_out_exponent    (io_out_exponent),
    .io_out_significand (io_out_significand),
    .io_out_class       (io_out_class)
  );

  typedef struct {
    logic [31:0] word;
    logic        sign;
    logic [7:0]  expo;
    logic [22:0] sig;
    logic [2:0]  cls;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } ent_t;

  vec_t  src[$];
  ent_t  q[$];
  int    nvec = 0;
  int    nerr = 0;
  int    cyc  = 0;
  bit    src_en = 1'b0;
  bit    hold_pend = 1'b0;
  logic [34:0] held;
  int    nan_m = 0;
  int    sub_m = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference classification from the numeric rules on plain integers.
  function automatic vec_t mk(input logic [31:0] w);
    vec_t v;
    int unsigned e;
    int unsigned m;
    e = int'(w[30:23]);
    m = int'(w[22:0]);
    v.word = w;
    v.sign = w[31];
    v.expo = w[30:23];
    v.sig  = w[22:0];
    if (e == 0)                 v.cls = (m == 0) ? 3'd0 : 3'd1;
    else if (e == 255 && m == 0) v.cls = 3'd3;
    else if (e == 255)           v.cls = (m >= (1 << 22)) ? 3'd4 : 3'd5;
    else                         v.cls = 3'd2;
    return v;
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [7:0]  e;
    logic [22:0] m;
    case ($urandom_range(0, 3))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      default: e = 8'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0:       m = 23'd0;
      1:       m = 23'h400000 | 23'($urandom);
      2:       m = 23'd1;
      default: m = 23'($urandom);
    endcase
    return {1'($urandom), e, m};
  endfunction

  // One clock: drive source, check against the model just before the edge.
  task automatic tick();
    bit in_fire;
    bit out_fire;
    bit exp_ov;
    ent_t e;
    io_in_valid = src_en && (src.size() > 0);
    io_in_bits  = (src.size() > 0) ? src[0].word : 32'hDEADBEEF;
    #1;
    in_fire  = io_in_valid && io_in_ready;
    out_fire = io_out_valid && io_out_ready;
    chk("in_ready", 64'(io_in_ready), 64'((q.size() < 2) || io_out_ready));
    exp_ov = (q.size() > 0) && (cyc - q[0].acc >= 2);
    chk("out_valid", 64'(io_out_valid), 64'(exp_ov));
    if (hold_pend)
      chk("hold_stable", 64'({io_out_sign, io_out_exponent, io_out_significand, io_out_class}),
          64'(held));
    hold_pend = 1'b0;
    if (io_out_valid && !io_out_ready) begin
      hold_pend = 1'b1;
      held = {io_out_sign, io_out_exponent, io_out_significand, io_out_class};
    end
    if (out_fire && q.size() > 0) begin
      e = q.pop_front();
      chk("sign", 64'(io_out_sign), 64'(e.v.sign));
      chk("exponent", 64'(io_out_exponent), 64'(e.v.expo));
      chk("significand", 64'(io_out_significand), 64'(e.v.sig));
      chk("class", 64'(io_out_class), 64'(e.v.cls));
      if ((e.v.cls == 3'd4 || e.v.cls == 3'd5) && nan_m < 65535) nan_m++;
      if (e.v.cls == 3'd1 && sub_m < 65535) sub_m++;
    end
    if (in_fire && !io_flush) begin
      e.v = src[0];
      e.acc = cyc;
      q.push_back(e);
    end
    if (in_fire) void'(src.pop_front());
    if (io_flush) begin
      q.delete();
      hold_pend = 1'b0;
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (src.size() == 0 && q.size() == 0) break;
      tick();
    end
    if (src.size() != 0 || q.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain_timeout: got %0d words left expected 0", src.size() + q.size());
    end
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{32'h3F800000, 1'b0, 8'h7F, 23'h000000, 3'd2};
    tbl[1]  = '{32'h80000000, 1'b1, 8'h00, 23'h000000, 3'd0};
    tbl[2]  = '{32'h00000001, 1'b0, 8'h00, 23'h000001, 3'd1};
    tbl[3]  = '{32'h7F800000, 1'b0, 8'hFF, 23'h000000, 3'd3};
    tbl[4]  = '{32'h7FC00000, 1'b0, 8'hFF, 23'h400000, 3'd4};
    tbl[5]  = '{32'h7F800001, 1'b0, 8'hFF, 23'h000001, 3'd5};
    tbl[6]  = '{32'hFF800000, 1'b1, 8'hFF, 23'h000000, 3'd3};
    tbl[7]  = '{32'hFFC00001, 1'b1, 8'hFF, 23'h400001, 3'd4};
    tbl[8]  = '{32'h00800000, 1'b0, 8'h01, 23'h000000, 3'd2};
    tbl[9]  = '{32'h007FFFFF, 1'b0, 8'h00, 23'h7FFFFF, 3'd1};
    tbl[10] = '{32'h7F7FFFFF, 1'b0, 8'hFE, 23'h7FFFFF, 3'd2};

    reset        = 1'b0;
    io_in_valid  = 1'b0;
    io_in_bits   = 32'd0;
    io_flush     = 1'b0;
    io_out_ready = 1'b1;
`ifdef FLOAT_UNPACK_STATS_EN
    io_stats_clear = 1'b0;
`endif
    #12;
    chk("reset_out_valid", 64'(io_out_valid), 64'd0);
    chk("reset_fields", 64'({io_out_sign, io_out_exponent, io_out_significand, io_out_class}), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("ready_after_reset", 64'(io_in_ready), 64'd1);

    // Single word, then valid drops once it is consumed.
    src_en = 1'b1;
    src.push_back(tbl[0]);
    drain(10);
    tick();

    // Remaining table entries back to back.
    for (int i = 1; i < 11; i++) src.push_back(tbl[i]);
    drain(30);

    // Backpressure: 3 stalled cycles after the first output.
    for (int i = 0; i < 4; i++) src.push_back(mk(rnd_word()));
    io_out_ready = 1'b1;
    tick(); tick(); tick();
    io_out_ready = 1'b0;
    tick(); tick(); tick();
    io_out_ready = 1'b1;
    drain(20);

    // Flush with both stages full and an input handshake in the same cycle.
    for (int i = 0; i < 3; i++) src.push_back(mk(rnd_word()));
    io_out_ready = 1'b0;
    tick(); tick(); tick();
    chk("flush_setup_occupancy", 64'(q.size()), 64'd2);
    io_flush = 1'b1;
    io_out_ready = 1'b1;
    tick();
    io_flush = 1'b0;
    src.delete();
    for (int i = 0; i < 4; i++) tick();

    // Asynchronous reset mid-stream, between edges.
    for (int i = 0; i < 3; i++) src.push_back(mk(rnd_word()));
    tick(); tick(); tick();
    src_en = 1'b0;
    io_in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("midreset_out_valid", 64'(io_out_valid), 64'd0);
    chk("midreset_fields", 64'({io_out_sign, io_out_exponent, io_out_significand, io_out_class}), 64'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    src.delete();
    q.delete();
    hold_pend = 1'b0;
    #1;
    chk("ready_after_midreset", 64'(io_in_ready), 64'd1);
    src_en = 1'b1;
    src.push_back(tbl[4]);
    drain(10);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      if (src.size() < 2) src.push_back(mk(rnd_word()));
      src_en       = ($urandom_range(0, 9) < 7);
      io_out_ready = ($urandom_range(0, 9) < 6);
      io_flush     = ($urandom_range(0, 49) == 0);
      tick();
    end
    io_flush = 1'b0;
    src.delete();
    io_out_ready = 1'b1;
    drain(10);

`ifdef FLOAT_UNPACK_STATS_EN
    io_stats_clear = 1'b1;
    tick();
    io_stats_clear = 1'b0;
    nan_m = 0;
    sub_m = 0;
    chk("stats_clear_nan", 64'(io_nan_count), 64'd0);
    src_en = 1'b1;
    for (int i = 0; i < 65537; i++) src.push_back(tbl[4]);
    drain(66000);
    chk("nan_saturated", 64'(io_nan_count), 64'(nan_m));
    chk("nan_is_ffff", 64'(io_nan_count), 64'hFFFF);
    chk("sub_count", 64'(io_subnormal_count), 64'(sub_m));
    io_stats_clear = 1'b1;
    tick();
    io_stats_clear = 1'b0;
    #1;
    chk("nan_cleared", 64'(io_nan_count), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
